// File: rtl/play_sequencer_pkg.sv
// Shared types and constants for the play-mode song sequencer.
package play_sequencer_pkg;

    localparam int CNT_W_DEF  = 8;
    localparam int OCT_W_DEF  = 3;
    localparam int NOTE_W_DEF = 3;
    localparam int LEN_W_DEF  = 3;
    localparam int TICK_W_DEF = 27;

    // Length codes 4 and above all mean a sixteenth note.
    localparam int MAX_LEN_SHIFT = 4;

    localparam logic [1:0] MOD_HALF   = 2'b10;
    localparam logic [1:0] MOD_DOUBLE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNTDOWN,
        S_FETCH,
        S_PLAY,
        S_GAP,
        S_PAUSED,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/seq_duration_calc.sv
// Combinational note duration: whole-note ticks scaled by length code and speed mode,
// saturating on half time and never returning zero.
module seq_duration_calc
    import play_sequencer_pkg::*;
#(
    parameter int LEN_W  = LEN_W_DEF,
    parameter int TICK_W = TICK_W_DEF
) (
    input  logic [TICK_W-1:0] full_note,
    input  logic [LEN_W-1:0]  length,
    input  logic [1:0]        mode,
    output logic [TICK_W-1:0] duration
);

    logic [TICK_W-1:0] base;
    logic [TICK_W-1:0] scaled;

    always_comb begin
        if (32'(length) >= MAX_LEN_SHIFT) begin
            base = full_note >> MAX_LEN_SHIFT;
        end else begin
            base = full_note >> length;
        end

        scaled = base;
        if (mode == MOD_HALF) begin
            scaled = base[TICK_W-1] ? '1 : (base << 1);
        end else if (mode == MOD_DOUBLE) begin
            scaled = base >> 1;
        end

        duration = (scaled == '0) ? TICK_W'(1) : scaled;
    end

endmodule

// File: rtl/play_sequencer.sv
// Play-mode sequencer: countdown, fetch each note over req/ack, sound it, then a silent gap.
// Define SEQ_LOOP_EN to restart from note 0 at song end and expose loop_pulse instead of done.
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_IDLE      | waiting for start
// S_COUNTDOWN | counting beats before the first note
// S_FETCH     | rd_req high, waiting for rd_ack for note idx
// S_PLAY      | goal note sounding for its duration
// S_GAP       | silent gap after a note
// S_PAUSED    | frozen; ret_state and cnt hold where to resume
// S_DONE      | song finished, goal fields hold the last note
module play_sequencer
    import play_sequencer_pkg::*;
#(
    parameter int CNT_W           = CNT_W_DEF,
    parameter int OCT_W           = OCT_W_DEF,
    parameter int NOTE_W          = NOTE_W_DEF,
    parameter int LEN_W           = LEN_W_DEF,
    parameter int TICK_W          = TICK_W_DEF,
    parameter int GAP_TICKS       = 1000000,
    parameter int COUNTDOWN_BEATS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    input  logic              abort,
    input  logic [1:0]        mod,
    input  logic [TICK_W-1:0] full_note,
    input  logic [CNT_W-1:0]  track_len,
    output logic              rd_req,
    output logic [CNT_W-1:0]  rd_addr,
    input  logic              rd_ack,
    input  logic [OCT_W-1:0]  rd_octave,
    input  logic [NOTE_W-1:0] rd_note,
    input  logic [LEN_W-1:0]  rd_length,
    output logic [OCT_W-1:0]  goal_octave,
    output logic [NOTE_W-1:0] goal_note,
    output logic [LEN_W-1:0]  goal_length,
    output logic              goal_valid,
    output logic              note_over,
    output logic [CNT_W-1:0]  idx,
    output logic              busy,
    output logic              done
`ifdef SEQ_LOOP_EN
    ,
    output logic              loop_pulse
`endif
);

    seq_state_t        state, next_state, ret_state, eff_state;
    logic [TICK_W-1:0] cnt;
    logic [TICK_W-1:0] full_note_q;
    logic [1:0]        mod_q;
    logic [OCT_W-1:0]  oct_q;
    logic [NOTE_W-1:0] note_q;
    logic [LEN_W-1:0]  len_q;
    logic [TICK_W-1:0] note_ticks;
    logic [TICK_W-1:0] countdown_ticks;
    logic              cnt_tc;
    logic              last_note;
    logic              hold;

    seq_duration_calc #(
        .LEN_W  (LEN_W),
        .TICK_W (TICK_W)
    ) u_duration (
        .full_note (full_note_q),
        .length    (rd_length),
        .mode      (mod_q),
        .duration  (note_ticks)
    );

    // Resuming from PAUSED acts as the stored state in the same cycle, so no tick is lost.
    assign eff_state       = (state == S_PAUSED && !pause) ? ret_state : state;
    assign hold            = pause && (eff_state inside {S_COUNTDOWN, S_PLAY, S_GAP});
    assign cnt_tc          = (cnt <= TICK_W'(1));
    assign last_note       = ({1'b0, idx} + 1'b1) >= {1'b0, track_len};
    assign countdown_ticks = TICK_W'(COUNTDOWN_BEATS) * (full_note >> 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = S_IDLE;
        end else if (hold) begin
            next_state = S_PAUSED;
        end else begin
            case (eff_state)
                S_IDLE, S_DONE: if (start) next_state = S_COUNTDOWN;
                S_COUNTDOWN: begin
                    if (cnt_tc) begin
`ifdef SEQ_LOOP_EN
                        next_state = (track_len == '0) ? S_IDLE : S_FETCH;
`else
                        next_state = (track_len == '0) ? S_DONE : S_FETCH;
`endif
                    end
                end
                S_FETCH: if (rd_ack) next_state = S_PLAY;
                S_PLAY:  if (cnt_tc) next_state = S_GAP;
                S_GAP: begin
                    if (cnt_tc) begin
`ifdef SEQ_LOOP_EN
                        next_state = S_FETCH;
`else
                        next_state = last_note ? S_DONE : S_FETCH;
`endif
                    end
                end
                default: next_state = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            mod_q       <= '0;
            full_note_q <= '0;
            ret_state   <= S_IDLE;
            oct_q       <= '0;
            note_q      <= '0;
            len_q       <= '0;
        end else if (abort) begin
            cnt <= '0;
            idx <= '0;
        end else if (hold) begin
            ret_state <= eff_state;
        end else begin
            case (eff_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mod_q       <= mod;
                        full_note_q <= full_note;
                        cnt         <= countdown_ticks;
                        idx         <= '0;
                    end
                end
                S_COUNTDOWN: if (!cnt_tc) cnt <= cnt - 1'b1;
                S_FETCH: begin
                    if (rd_ack) begin
                        oct_q  <= rd_octave;
                        note_q <= rd_note;
                        len_q  <= rd_length;
                        cnt    <= note_ticks;
                    end
                end
                S_PLAY: cnt <= cnt_tc ? TICK_W'(GAP_TICKS) : cnt - 1'b1;
                S_GAP: begin
                    if (!cnt_tc) begin
                        cnt <= cnt - 1'b1;
                    end else if (!last_note) begin
                        idx <= idx + 1'b1;
                    end
`ifdef SEQ_LOOP_EN
                    else begin
                        idx <= '0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_req     = (state == S_FETCH);
        goal_valid = (eff_state == S_PLAY) && !pause && !abort;
        note_over  = goal_valid && cnt_tc;
        busy       = !(state inside {S_IDLE, S_DONE});
        done       = (state == S_DONE);
    end

`ifdef SEQ_LOOP_EN
    assign loop_pulse = (eff_state == S_GAP) && !pause && !abort && cnt_tc && last_note;
`endif

    assign rd_addr     = idx;
    assign goal_octave = oct_q;
    assign goal_note   = note_q;
    assign goal_length = len_q;

endmodule
